// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: register index width,
// scoreboard slot layout, stage slot indices and the slot hit compare.
package hazard_ctrl_pkg;

  localparam int REG_IDX_W = 32'd3;
  localparam int SB_DEPTH  = 32'd3;
  localparam int SB_EX     = 32'd0;
  localparam int SB_MEM    = 32'd1;
  localparam int SB_WB     = 32'd2;

  typedef struct packed {
    logic                 v;
    logic [REG_IDX_W-1:0] idx;
  } sb_slot_t;

  localparam sb_slot_t SLOT_EMPTY = '{v: 1'b0, idx: 3'd0};

  // A slot hits when it holds a pending write to a register the ID instruction reads.
  function automatic logic slot_hit(input sb_slot_t             slot,
                                    input logic [REG_IDX_W-1:0] rs,
                                    input logic                 rs_used,
                                    input logic [REG_IDX_W-1:0] rt,
                                    input logic                 rt_used);
    logic rs_match;
    logic rt_match;
    rs_match = (slot.idx == rs) & rs_used;
    rt_match = (slot.idx == rt) & rt_used;
    return slot.v & (rs_match | rt_match);
  endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Three-slot destination scoreboard mirroring EX/MEM/WB, with per-slot RAW hit
// detection against the instruction currently in decode.
module hazard_ctrl_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  sb_slot_t             ins_slot,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic                 id_rs_used,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_rt_used,
  output logic [SB_DEPTH-1:0]  hit
);

  sb_slot_t sb_r [SB_DEPTH];

  // Slots advance one stage per unfrozen cycle; a frozen pipeline keeps them in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_r[i] <= SLOT_EMPTY;
      end
    end else if (!hold) begin
      sb_r[SB_WB]  <= sb_r[SB_MEM];
      sb_r[SB_MEM] <= sb_r[SB_EX];
      sb_r[SB_EX]  <= ins_slot;
    end
  end

  // Per-slot hit vector for the decode-stage sources.
  always_comb begin
    hit = {SB_DEPTH{1'b0}};
    for (int i = 0; i < SB_DEPTH; i++) begin
      hit[i] = slot_hit(sb_r[i], id_rs, id_rs_used, id_rt, id_rt_used);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline without forwarding:
// RAW stalls, EX redirect flushes, memory-busy freeze and halt drain.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 32'd8,
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 32'd16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [$clog2(NUM_REGS)-1:0] id_rs,
  input  logic                       id_rs_used,
  input  logic [$clog2(NUM_REGS)-1:0] id_rt,
  input  logic                       id_rt_used,
  input  logic                       id_regwrite,
  input  logic [$clog2(NUM_REGS)-1:0] id_wreg,
  input  logic                       id_halt,
  input  logic                       ex_redirect,
  input  logic                       mem_busy,
  output logic                       stall,
  output logic                       flush_ifid,
  output logic                       flush_idex,
  output logic                       freeze,
  output logic                       fetch_en,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic             WB_CHK  = (RF_BYPASS == 1'b0);

  logic [SB_DEPTH-1:0] hit_s;
  logic                raw_s;
  logic                stall_s;
  logic                flush_s;
  logic                freeze_s;
  sb_slot_t            ins_slot_s;
  logic                halt_pend_r;
  logic [CNT_W-1:0]    stall_cnt_r;

  hazard_ctrl_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .hold       (freeze_s),
    .ins_slot   (ins_slot_s),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rt      (id_rt),
    .id_rt_used (id_rt_used),
    .hit        (hit_s)
  );

  // With a write-before-read register file the WB slot cannot cause a hazard.
  assign raw_s = id_valid & (hit_s[SB_EX] | hit_s[SB_MEM] | (WB_CHK & hit_s[SB_WB]));

  // Priority: freeze over redirect over RAW stall.
  always_comb begin
    stall_s  = 1'b0;
    flush_s  = 1'b0;
    freeze_s = 1'b0;
    if (mem_busy) begin
      freeze_s = 1'b1;
    end else if (ex_redirect) begin
      flush_s = 1'b1;
    end else if (raw_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Bubbles (stall or flush) enter the scoreboard as empty slots.
  always_comb begin
    ins_slot_s.v   = id_valid & id_regwrite & ~stall_s & ~flush_s;
    ins_slot_s.idx = id_wreg;
  end

  // Halt stays pending until reset or a redirect proves it was on the wrong path.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_pend_r <= 1'b0;
    end else if (!freeze_s) begin
      if (ex_redirect) begin
        halt_pend_r <= 1'b0;
      end else if (id_valid && id_halt && !stall_s) begin
        halt_pend_r <= 1'b1;
      end
    end
  end

  // Saturating count of unfrozen stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && !freeze_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end
  end

  assign stall      = stall_s;
  assign flush_ifid = flush_s;
  assign flush_idex = flush_s;
  assign freeze     = freeze_s;
  assign fetch_en   = ~halt_pend_r & ~stall_s & ~freeze_s;
  assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one bypassed 4-bit-counter instance and one
// non-bypassed instance sharing the same stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_halt;
  logic [2:0] id_rs, id_rt, id_wreg;
  logic       ex_redirect, mem_busy;

  logic        stall, flush_ifid, flush_idex, freeze, fetch_en;
  logic [3:0]  stall_cnt;
  logic        stall0, flush_ifid0, flush_idex0, freeze0, fetch_en0;
  logic [15:0] stall_cnt0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.NUM_REGS(8), .RF_BYPASS(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_regwrite(id_regwrite), .id_wreg(id_wreg),
    .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex), .freeze(freeze),
    .fetch_en(fetch_en), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.NUM_REGS(8), .RF_BYPASS(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_regwrite(id_regwrite), .id_wreg(id_wreg),
    .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall(stall0), .flush_ifid(flush_ifid0), .flush_idex(flush_idex0), .freeze(freeze0),
    .fetch_en(fetch_en0), .stall_cnt(stall_cnt0)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output vector order: {stall, flush_ifid, flush_idex, freeze, fetch_en}
  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {11'd0, stall, flush_ifid, flush_idex, freeze, fetch_en}, {11'd0, exp});
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic rsu,
                        input logic [2:0] rt, input logic rtu, input logic rw,
                        input logic [2:0] wr, input logic h);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_regwrite = rw; id_wreg = wr; id_halt = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drain();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    ex_redirect = 1'b0;
    mem_busy    = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; mem_busy = 1'b0;
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(); tick();
    rst = 1'b0; settle();
    chk_out("reset_outs", 5'b00001);
    chk("reset_cnt", {12'd0, stall_cnt}, 16'd0);

    // Back-to-back RAW: add r3 then add r4,r3,r1
    set_id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0); settle();
    chk_out("raw_producer", 5'b00001); tick();
    set_id(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b1, 3'd4, 1'b0); settle();
    chk_out("raw_stall1", 5'b10000);
    chk("raw_stall1_nobyp", {15'd0, stall0}, 16'd1); tick();
    settle(); chk_out("raw_stall2", 5'b10000); tick();
    settle(); chk_out("raw_proceed", 5'b00001);
    chk("raw_stall3_nobyp", {15'd0, stall0}, 16'd1);
    chk("raw_cnt", {12'd0, stall_cnt}, 16'd2); tick();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); settle();
    chk("raw_nobyp_done", {15'd0, stall0}, 16'd0);
    chk("raw_nobyp_cnt", stall_cnt0, 16'd3);
    drain();

    // Independent instructions, then probe r2 in MEM and WB
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0); settle();
    chk_out("indep_w2", 5'b00001); tick();
    set_id(1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0); settle();
    chk_out("indep_r56", 5'b00001); tick();
    set_id(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); settle();
    chk_out("r2_in_mem", 5'b10000); tick();
    settle(); chk_out("r2_in_wb_bypass", 5'b00001);
    chk("indep_cnt", {12'd0, stall_cnt}, 16'd3);
    drain();

    // r0 is an ordinary register
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0); tick();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0); settle();
    chk_out("r0_hazard", 5'b10000); tick();
    drain();

    // Unused source fields never hazard
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0); tick();
    set_id(1'b1, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0); settle();
    chk_out("unused_src", 5'b00001);
    chk("unused_cnt", {12'd0, stall_cnt}, 16'd4);
    drain();

    // Redirect overrides RAW and inserts a bubble
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0); tick();
    set_id(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0);
    ex_redirect = 1'b1; settle();
    chk_out("redir_over_raw", 5'b01101); tick();
    ex_redirect = 1'b0;
    set_id(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); settle();
    chk_out("redir_bubble", 5'b00001);
    chk("redir_cnt", {12'd0, stall_cnt}, 16'd4);
    drain();

    // mem_busy freezes a pending stall; redirect under freeze is ignored
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0); tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); settle();
    chk_out("busy_pre_stall", 5'b10000); tick();
    mem_busy = 1'b1; settle();
    chk_out("busy_1", 5'b00010);
    chk("busy_1_cnt", {12'd0, stall_cnt}, 16'd5); tick();
    ex_redirect = 1'b1; settle();
    chk_out("busy_2_redir", 5'b00010); tick();
    ex_redirect = 1'b0; settle();
    chk_out("busy_3", 5'b00010);
    chk("busy_3_cnt", {12'd0, stall_cnt}, 16'd5); tick();
    mem_busy = 1'b0; settle();
    chk_out("busy_resume", 5'b10000);
    chk("busy_resume_cnt", {12'd0, stall_cnt}, 16'd5); tick();
    settle(); chk_out("busy_done", 5'b00001);
    chk("busy_done_cnt", {12'd0, stall_cnt}, 16'd6);
    drain();

    // Halt drain and redirect release
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1); settle();
    chk_out("halt_accept", 5'b00001); tick();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); settle();
    chk_out("halt_pending", 5'b00000); tick();
    settle(); chk_out("halt_holds", 5'b00000);
    ex_redirect = 1'b1; settle();
    chk_out("halt_redir", 5'b01100); tick();
    ex_redirect = 1'b0; settle();
    chk_out("halt_cleared", 5'b00001);
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    ex_redirect = 1'b1; tick();
    ex_redirect = 1'b0;
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); settle();
    chk_out("halt_with_redir", 5'b00001);
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    mem_busy = 1'b1; tick();
    mem_busy = 1'b0;
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); settle();
    chk_out("halt_frozen", 5'b00001);
    drain();

    // Counter saturation: each producer/consumer pair adds two stall cycles
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0); tick();
      set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0); tick(); tick(); tick();
    end
    settle(); chk("cnt_14", {12'd0, stall_cnt}, 16'd14);
    for (int i = 0; i < 6; i++) begin
      set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0); tick();
      set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0); tick(); tick(); tick();
    end
    settle(); chk("cnt_saturated", {12'd0, stall_cnt}, 16'd15);

    // Reset in the middle of a stall
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0); tick();
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0); settle();
    chk_out("pre_rst_stall", 5'b10000);
    rst = 1'b1; tick();
    rst = 1'b0; settle();
    chk_out("post_rst_outs", 5'b00001);
    chk("post_rst_cnt", {12'd0, stall_cnt}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
